// File: rtl/mem_dump_pkg.sv
// Shared types and character helpers for the memory dump formatter.
// Holds the FSM state encoding plus hex/printable conversions.
package mem_dump_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    HDR,
    HEX,
    GAP,
    ASC,
    NEXT,
    DONE
  } dump_state_e;

  localparam logic [7:0] NL    = 8'h0a;
  localparam logic [7:0] SP    = 8'h20;
  localparam logic [7:0] COLON = 8'h3a;

  function automatic logic [7:0] nib2hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'd0, n}) : (8'h57 + {4'd0, n});
  endfunction

  function automatic logic printable(input logic [7:0] b);
    return (b >= 8'h20) && (b < 8'h7f);
  endfunction

endpackage

// File: rtl/mem_dump_fmt.sv
// Walks a byte memory region row by row and streams a hex + ASCII listing
// one character at a time over a valid/ready interface.
module mem_dump_fmt
  import mem_dump_pkg::*;
#(
  parameter int         ASZ      = 17,
  parameter int         ROW      = 16,
  parameter int         GRP      = 4,
  parameter int         ASCII_EN = 1,
  parameter logic [7:0] DOT      = 8'h2e
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic [ASZ-1:0] base_i,
  input  logic [ASZ-1:0] len_i,
  input  logic           abort_i,
  output logic           mem_re_o,
  output logic [ASZ-1:0] mem_addr_o,
  input  logic [7:0]     mem_data_i,
  output logic [7:0]     ch_o,
  output logic           ch_valid_o,
  input  logic           ch_ready_i,
  output logic           busy_o,
  output logic           done_o
);

  localparam int ADIG = (ASZ + 3) / 4;
  localparam int AXW  = 4 * ADIG;
  localparam int RW   = $clog2(ROW);
  localparam int IW   = $clog2(ROW + ADIG + 2) + 1;

  localparam logic [IW-1:0]  C_ONE     = IW'(1);
  localparam logic [IW-1:0]  C_ROW     = IW'(ROW);
  localparam logic [IW-1:0]  C_ROW_M1  = IW'(ROW - 1);
  localparam logic [IW-1:0]  C_HDR_END = IW'(ADIG + 1);
  localparam logic [IW-1:0]  C_GRP_M1  = IW'(GRP - 1);
  localparam logic [ASZ-1:0] C_MASK    = ~ASZ'(ROW - 1);
  localparam logic [ASZ-1:0] C_STEP    = ASZ'(ROW);
  localparam logic [ASZ-1:0] C_AONE    = ASZ'(1);

  dump_state_e    r_state, w_next;
  logic [ASZ-1:0] r_a1, r_last;
  logic [IW-1:0]  r_idx;
  logic [1:0]     r_ph;
  logic           r_abort;
  logic [7:0]     r_buf [ROW];

  logic           w_acc, w_abort;
  logic [ASZ-1:0] w_end;
  logic [7:0]     w_byte;
  logic [3:0]     w_hdr_nib;

  assign w_acc     = ch_valid_o && ch_ready_i;
  assign w_abort   = r_abort || abort_i;
  // Only the low ASZ bits of the end address matter once rows wrap mod 2^ASZ.
  assign w_end     = base_i + len_i - C_AONE;
  assign w_byte    = r_buf[RW'(r_idx)];
  assign w_hdr_nib = 4'(AXW'(r_a1) >> (4 * (ADIG - int'(r_idx))));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (start_i) w_next = (len_i == '0) ? DONE : FETCH;
      FETCH: if (w_abort) w_next = DONE;
             else if (r_idx == C_ROW) w_next = HDR;
      HDR:   if (w_acc) begin
               if (w_abort) w_next = DONE;
               else if (r_idx == C_HDR_END) w_next = HEX;
             end
      HEX:   if (w_acc) begin
               if (w_abort) w_next = DONE;
               else if (r_idx == C_ROW_M1 && r_ph == 2'd2) w_next = (ASCII_EN != 0) ? GAP : NEXT;
             end
      GAP:   if (w_acc) begin
               if (w_abort) w_next = DONE;
               else if (r_idx == C_ONE) w_next = ASC;
             end
      ASC:   if (w_acc) begin
               if (w_abort) w_next = DONE;
               else if (r_idx == C_ROW_M1) w_next = NEXT;
             end
      NEXT:  w_next = (r_a1 == r_last || w_abort) ? DONE : FETCH;
      DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a1    <= '0;
      r_last  <= '0;
      r_idx   <= '0;
      r_ph    <= 2'd0;
      r_abort <= 1'b0;
    end else begin
      if (r_state == IDLE || r_state == DONE) r_abort <= 1'b0;
      else if (abort_i)                       r_abort <= 1'b1;

      if (r_state == IDLE && start_i) begin
        r_a1   <= base_i & C_MASK;
        r_last <= w_end & C_MASK;
      end
      if (r_state == NEXT && w_next == FETCH) r_a1 <= r_a1 + C_STEP;

      // Every state starts its own walk from index 0; r_ph 0 is the group space.
      if (w_next != r_state) begin
        r_idx <= '0;
        r_ph  <= 2'd0;
      end else begin
        case (r_state)
          FETCH:       r_idx <= r_idx + C_ONE;
          HDR, GAP, ASC: if (w_acc) r_idx <= r_idx + C_ONE;
          HEX: if (w_acc) begin
            case (r_ph)
              2'd0: r_ph <= 2'd1;
              2'd1: r_ph <= 2'd2;
              default: begin
                r_idx <= r_idx + C_ONE;
                r_ph  <= (((r_idx + C_ONE) & C_GRP_M1) == '0) ? 2'd0 : 2'd1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  // Read data arrives one cycle late, so slot idx-1 is written at index idx.
  always_ff @(posedge clk) begin
    if (r_state == FETCH && r_idx != '0) r_buf[RW'(r_idx - C_ONE)] <= mem_data_i;
  end

  always_comb begin
    mem_re_o   = 1'b0;
    mem_addr_o = '0;
    ch_o       = 8'h00;
    ch_valid_o = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    case (r_state)
      FETCH: begin
        busy_o = 1'b1;
        if (r_idx < C_ROW) begin
          mem_re_o   = 1'b1;
          mem_addr_o = r_a1 + ASZ'(r_idx);
        end
      end
      HDR: begin
        busy_o     = 1'b1;
        ch_valid_o = 1'b1;
        if (r_idx == '0)            ch_o = NL;
        else if (r_idx == C_HDR_END) ch_o = COLON;
        else                        ch_o = nib2hex(w_hdr_nib);
      end
      HEX: begin
        busy_o     = 1'b1;
        ch_valid_o = 1'b1;
        case (r_ph)
          2'd0:    ch_o = SP;
          2'd1:    ch_o = nib2hex(w_byte[7:4]);
          default: ch_o = nib2hex(w_byte[3:0]);
        endcase
      end
      GAP: begin
        busy_o     = 1'b1;
        ch_valid_o = 1'b1;
        ch_o       = SP;
      end
      ASC: begin
        busy_o     = 1'b1;
        ch_valid_o = 1'b1;
        ch_o       = printable(w_byte) ? w_byte : DOT;
      end
      NEXT:    busy_o = 1'b1;
      DONE:    done_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_dump_fmt.sv
// Scoreboard bench for mem_dump_fmt: stimulus queues expected chars and read
// addresses, a monitor pops and compares them as the DUT presents them.
module tb_mem_dump_fmt;
  localparam int ASZ = 17;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start_i = 1'b0, abort_i = 1'b0, ch_ready_i = 1'b1;
  logic [ASZ-1:0] base_i = '0, len_i = '0;
  logic           mem_re_o, ch_valid_o, busy_o, done_o;
  logic [ASZ-1:0] mem_addr_o;
  logic [7:0]     mem_data_i, ch_o;

  logic [7:0]     mem [0:(1<<ASZ)-1];
  logic [7:0]     exp_q[$];
  logic [ASZ-1:0] exp_addr_q[$];
  int             checks = 0, errors = 0, done_cnt = 0, acc_cnt = 0;
  bit             chk_rd = 1'b1, rand_rdy = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) mem_data_i <= mem[mem_addr_o];

  mem_dump_fmt dut (
    .clk(clk), .rst(rst), .start_i(start_i), .base_i(base_i), .len_i(len_i),
    .abort_i(abort_i), .mem_re_o(mem_re_o), .mem_addr_o(mem_addr_o),
    .mem_data_i(mem_data_i), .ch_o(ch_o), .ch_valid_o(ch_valid_o),
    .ch_ready_i(ch_ready_i), .busy_o(busy_o), .done_o(done_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic push_reads(input logic [ASZ-1:0] a);
    for (int i = 0; i < 16; i++) exp_addr_q.push_back(a + ASZ'(i));
  endtask

  // Reference formatter for one 16-byte row at aligned address a.
  task automatic push_row(input logic [ASZ-1:0] a);
    string s;
    logic [7:0] b;
    s = $sformatf("\n%05h:", a);
    for (int i = 0; i < 16; i++) begin
      if (i % 4 == 0) s = {s, " "};
      s = {s, $sformatf("%02h", mem[a + ASZ'(i)])};
    end
    s = {s, "  "};
    for (int i = 0; i < 16; i++) begin
      b = mem[a + ASZ'(i)];
      s = {s, $sformatf("%c", (b >= 8'h20 && b < 8'h7f) ? b : 8'h2e)};
    end
    push_str(s);
    push_reads(a);
  endtask

  task automatic start_dump(input logic [ASZ-1:0] b, input logic [ASZ-1:0] l, input bit ab);
    @(posedge clk); #1;
    start_i = 1'b1; base_i = b; len_i = l; abort_i = ab;
    @(posedge clk); #1;
    start_i = 1'b0; abort_i = 1'b0;
  endtask

  task automatic finish_dump(input string name, input int d0, input int a0, input int nch);
    bit seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
    end
    chk({name, "_done_seen"}, 64'(seen), 64'd1);
    repeat (2) @(negedge clk);
    chk({name, "_done_cnt"}, 64'(done_cnt - d0), 64'd1);
    chk({name, "_nchars"}, 64'(acc_cnt - a0), 64'(nch));
    chk({name, "_q_empty"}, 64'(exp_q.size() + exp_addr_q.size()), 64'd0);
    chk({name, "_idle"}, {busy_o, ch_valid_o, mem_re_o}, 64'd0);
  endtask

  initial begin
    int d0, a0;
    bit prev_stall = 1'b0;
    logic [7:0] prev_ch = 8'h00;
    string t1 = "\n01000: 61626364 65666768 696a6b6c 6d6e6f70  abcdefghijklmnop";
    string t3 = "\n02000: 001f207e 7f80ff41 41414141 41414141  .. ~...AAAAAAAAA";
    logic [7:0] t3b [7] = '{8'h00, 8'h1f, 8'h20, 8'h7e, 8'h7f, 8'h80, 8'hff};

    for (int a = 0; a < (1 << ASZ); a++) mem[a] = 8'((a * 13) + 5);
    for (int i = 0; i < 16; i++) mem[17'h01000 + 17'(i)] = 8'h61 + 8'(i);
    for (int i = 0; i < 16; i++) mem[17'h02000 + 17'(i)] = (i < 7) ? t3b[i] : 8'h41;

    fork
      forever begin
        @(negedge clk);
        if (rst) begin
          prev_stall = 1'b0;
          continue;
        end
        if (ch_valid_o && ch_ready_i) begin
          acc_cnt++;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL extra_char: got %02h expected none", ch_o);
          end else chk("char", ch_o, exp_q.pop_front());
        end
        if (prev_stall) chk("stall_hold", {ch_valid_o, ch_o}, {1'b1, prev_ch});
        prev_stall = ch_valid_o && !ch_ready_i;
        prev_ch    = ch_o;
        if (mem_re_o && chk_rd) begin
          if (exp_addr_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL extra_read: got %05h expected none", mem_addr_o);
          end else chk("rd_addr", mem_addr_o, exp_addr_q.pop_front());
        end
        if (done_o) done_cnt++;
      end
      forever begin
        @(posedge clk); #1;
        if (rand_rdy) ch_ready_i = ($urandom_range(0, 9) < 3);
      end
    join_none

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_outs", {mem_re_o, ch_valid_o, busy_o, done_o, ch_o, mem_addr_o}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // 1: single aligned row
    d0 = done_cnt; a0 = acc_cnt;
    push_str(t1); push_reads(17'h01000);
    start_dump(17'h01000, 17'h10, 1'b0);
    chk("t1_busy", busy_o, 1'b1);
    finish_dump("t1", d0, a0, 61);

    // 2: unaligned base spans two rows; abort together with start is ignored
    d0 = done_cnt; a0 = acc_cnt;
    push_row(17'h01000); push_row(17'h01010);
    start_dump(17'h01005, 17'h10, 1'b1);
    finish_dump("t2", d0, a0, 122);

    // 3: non-printable substitution
    d0 = done_cnt; a0 = acc_cnt;
    push_str(t3); push_reads(17'h02000);
    start_dump(17'h02000, 17'h07, 1'b0);
    finish_dump("t3", d0, a0, 61);

    // 4: random backpressure
    d0 = done_cnt; a0 = acc_cnt;
    push_str(t1); push_reads(17'h01000);
    rand_rdy = 1'b1;
    start_dump(17'h01000, 17'h10, 1'b0);
    finish_dump("t4", d0, a0, 61);
    rand_rdy = 1'b0;
    @(posedge clk); #1 ch_ready_i = 1'b1;

    // 5a: zero length
    d0 = done_cnt; a0 = acc_cnt;
    start_dump(17'h01000, 17'h0, 1'b0);
    chk("t5_done_now", {done_o, busy_o}, 2'b10);
    @(posedge clk); #1;
    chk("t5_done_after", {done_o, busy_o}, 2'b00);
    repeat (3) @(negedge clk);
    chk("t5_done_cnt", 64'(done_cnt - d0), 64'd1);
    chk("t5_nchars", 64'(acc_cnt - a0), 64'd0);

    // 5b: start while busy is ignored
    d0 = done_cnt; a0 = acc_cnt;
    push_str(t1); push_reads(17'h01000);
    start_dump(17'h01000, 17'h10, 1'b0);
    repeat (5) @(posedge clk);
    #1 start_i = 1'b1; base_i = 17'h02000;
    @(posedge clk); #1 start_i = 1'b0;
    finish_dump("t5b", d0, a0, 61);

    // Abort during fetch: no chars, done once
    d0 = done_cnt; a0 = acc_cnt;
    chk_rd = 1'b0;
    start_dump(17'h01000, 17'h40, 1'b0);
    abort_i = 1'b1;
    @(posedge clk); #1 abort_i = 1'b0;
    finish_dump("abort", d0, a0, 0);
    chk_rd = 1'b1;

    // 6: row address wraps
    d0 = done_cnt; a0 = acc_cnt;
    push_row(17'h1fff0); push_row(17'h00000);
    start_dump(17'h1fff0, 17'h20, 1'b0);
    finish_dump("t6", d0, a0, 122);

    // 6b: reset in the middle of HEX
    d0 = done_cnt; a0 = acc_cnt;
    push_row(17'h01000);
    start_dump(17'h01000, 17'h40, 1'b0);
    for (int i = 0; i < 500 && (acc_cnt - a0) < 20; i++) @(negedge clk);
    chk("t6b_reached_hex", 64'((acc_cnt - a0) >= 20), 64'd1);
    rst = 1'b1;
    #1;
    chk("t6b_reset_outs", {mem_re_o, ch_valid_o, busy_o, done_o, ch_o, mem_addr_o}, 64'd0);
    exp_q.delete(); exp_addr_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6b_no_done", 64'(done_cnt - d0), 64'd0);

    d0 = done_cnt; a0 = acc_cnt;
    push_str(t1); push_reads(17'h01000);
    start_dump(17'h01000, 17'h10, 1'b0);
    finish_dump("t6c", d0, a0, 61);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
